sprite_rom_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/rr_pick.sv | 33 +++
 rtl/sprite_rom_arbiter.sv | 86 ++++++++
 tb/tb_sprite_rom_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the sprite ROM arbiter
package vga_pkg;

    localparam int NB_REQ  = 4;
    localparam int ROM_AW  = 12;
    localparam int ROM_DW  = 24;
    localparam int ROM_LAT = 2;
    localparam int ID_W    = $clog2(NB_REQ);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rom_tag_t;

    localparam req_id_t REQ_MAP  = req_id_t'(0);
    localparam req_id_t REQ_P1   = req_id_t'(1);
    localparam req_id_t REQ_P2   = req_id_t'(2);
    localparam req_id_t REQ_BOMB = req_id_t'(3);

    // Successor of a requester index, wrapping at NB_REQ (not necessarily a power of two).
    function automatic req_id_t next_id(input req_id_t id);
        return (int'(id) == NB_REQ - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the scan at ptr
module rr_pick
    import vga_pkg::*;
(
    input  logic [NB_REQ-1:0] req,
    input  req_id_t           ptr,
    output logic [NB_REQ-1:0] gnt,
    output req_id_t           winner,
    output logic              any
);

    int      slot;
    req_id_t cand;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        slot   = 0;
        cand   = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NB_REQ) slot = slot - NB_REQ;
            cand = req_id_t'(slot);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
        if (any) gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of one sprite ROM read port, tagged returns
module sprite_rom_arbiter
    import vga_pkg::*;
(
    input  logic                     clock_50,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [NB_REQ-1:0]        req,
    input  logic [NB_REQ*ROM_AW-1:0] addr,
    output logic [NB_REQ-1:0]        gnt,
    output logic [NB_REQ-1:0]        rvalid,
    output logic [ROM_DW-1:0]        rdata,
    output logic                     rom_rd,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [ROM_DW-1:0]        rom_q,
    output logic [2:0]               inflight
);

    req_id_t           ptr;
    req_id_t           winner;
    logic              any;
    logic              grant;
    logic [NB_REQ-1:0] pick_gnt;
    logic [ROM_AW-1:0] sel_addr;
    rom_tag_t          tags [ROM_LAT+1];
    rom_tag_t          ret_tag;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (winner),
        .any    (any)
    );

    assign grant   = any && !flush;
    assign gnt     = (grant && reset_n) ? pick_gnt : '0;
    assign ret_tag = tags[ROM_LAT];

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (req_id_t'(i) == winner) sel_addr = addr[i*ROM_AW +: ROM_AW];
        end
    end

    // tags[k] is visible k+1 cycles after the grant; tags[ROM_LAT] lines up with rom_q.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            inflight <= '0;
            for (int k = 0; k <= ROM_LAT; k++) tags[k] <= '0;
        end else begin
            rom_rd <= grant;
            if (grant) begin
                rom_addr <= sel_addr;
                ptr      <= next_id(winner);
            end

            rvalid <= '0;
            if (ret_tag.valid && !flush) begin
                rvalid[ret_tag.id] <= 1'b1;
                rdata              <= rom_q;
            end

            tags[0] <= '{valid: grant, id: winner};
            for (int k = 1; k <= ROM_LAT; k++) begin
                tags[k] <= flush ? rom_tag_t'('0) : tags[k-1];
            end

            // A read stops counting on the edge that raises its rvalid.
            if (flush) begin
                inflight <= '0;
            end else if (grant && !ret_tag.valid) begin
                inflight <= inflight + 3'd1;
            end else if (!grant && ret_tag.valid) begin
                inflight <= inflight - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter
    import vga_pkg::*;
();

    logic                     clock_50 = 1'b0;
    logic                     reset_n  = 1'b0;
    logic                     flush    = 1'b0;
    logic [NB_REQ-1:0]        req      = '0;
    logic [NB_REQ*ROM_AW-1:0] addr     = '0;
    logic [NB_REQ-1:0]        gnt;
    logic [NB_REQ-1:0]        rvalid;
    logic [ROM_DW-1:0]        rdata;
    logic                     rom_rd;
    logic [ROM_AW-1:0]        rom_addr;
    logic [ROM_DW-1:0]        rom_q;
    logic [2:0]               inflight;

    sprite_rom_arbiter dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .flush    (flush),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .inflight (inflight)
    );

    always #5 clock_50 = ~clock_50;

    int cyc = 0;
    always @(posedge clock_50) cyc <= cyc + 1;

    function automatic logic [ROM_DW-1:0] rom_fn(input logic [ROM_AW-1:0] a);
        if (a == 12'h1A3) return 24'hABCDEF;
        return {a ^ 12'hC35, a};
    endfunction

    // Behavioural ROM: data for the address presented with rom_rd appears ROM_LAT cycles later.
    logic [ROM_DW-1:0] rom_pipe [ROM_LAT];
    always @(posedge clock_50) begin
        rom_pipe[0] <= rom_rd ? rom_fn(rom_addr) : '0;
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    typedef struct {
        int                grant;
        int                due;
        int                id;
        logic [ROM_DW-1:0] data;
        int                kill;
    } ret_t;

    typedef struct {
        int                at;
        logic              rd;
        logic [ROM_AW-1:0] a;
    } iss_t;

    logic [NB_REQ-1:0] gnt_q [$];
    iss_t              iss_q [$];
    ret_t              ret_q [$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    int                ptr_m = 0;
    logic [ROM_AW-1:0] addr_v [NB_REQ];

    // Drive one cycle of stimulus and record what the arbiter should do with it.
    task automatic step(input logic [NB_REQ-1:0] r, input logic fl);
        int                w;
        logic [NB_REQ-1:0] eg;
        @(posedge clock_50);
        #1;
        req   = r;
        flush = fl;
        for (int i = 0; i < NB_REQ; i++) addr[i*ROM_AW +: ROM_AW] = addr_v[i];
        eg = '0;
        w  = -1;
        if (!fl) begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (w < 0 && r[(ptr_m + k) % NB_REQ]) w = (ptr_m + k) % NB_REQ;
            end
        end else begin
            foreach (ret_q[i]) if (ret_q[i].kill < 0 && ret_q[i].due > cyc) ret_q[i].kill = cyc;
        end
        if (w >= 0) begin
            eg[w] = 1'b1;
            ptr_m = (w + 1) % NB_REQ;
            ret_q.push_back('{grant: cyc, due: cyc + 2 + ROM_LAT, id: w,
                              data: rom_fn(addr_v[w]), kill: -1});
            iss_q.push_back('{at: cyc + 1, rd: 1'b1, a: addr_v[w]});
            addr_v[w] = ROM_AW'($urandom);
        end else begin
            iss_q.push_back('{at: cyc + 1, rd: 1'b0, a: '0});
        end
        gnt_q.push_back(eg);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock_50);
        #1;
        reset_n = 1'b0;
        req     = '0;
        flush   = 1'b0;
        gnt_q.delete();
        iss_q.delete();
        ret_q.delete();
        ptr_m = 0;
        repeat (n) @(posedge clock_50);
        #1;
        reset_n = 1'b1;
    endtask

    iss_t ie;
    ret_t re;
    int   live;

    always @(negedge clock_50) begin
        if (!reset_n) begin
            chk("rst_gnt", 32'(gnt), 32'(0));
            chk("rst_rom_rd", 32'(rom_rd), 32'(0));
            chk("rst_rvalid", 32'(rvalid), 32'(0));
            chk("rst_rdata", 32'(rdata), 32'(0));
            chk("rst_inflight", 32'(inflight), 32'(0));
        end else begin
            if (gnt_q.size() > 0) chk("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
            if (iss_q.size() > 0 && iss_q[0].at == cyc) begin
                ie = iss_q.pop_front();
                chk("rom_rd", 32'(rom_rd), 32'(ie.rd));
                if (ie.rd) chk("rom_addr", 32'(rom_addr), 32'(ie.a));
            end
            while (ret_q.size() > 0 && ret_q[0].kill >= 0 && cyc > ret_q[0].kill) ret_q.delete(0);
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                re = ret_q.pop_front();
                chk("rvalid", 32'(rvalid), 32'(1) << re.id);
                chk("rdata", 32'(rdata), 32'(re.data));
            end else begin
                chk("rvalid_idle", 32'(rvalid), 32'(0));
            end
            live = 0;
            foreach (ret_q[i]) begin
                if (ret_q[i].grant < cyc && (ret_q[i].kill < 0 || cyc <= ret_q[i].kill)) live++;
            end
            chk("inflight", 32'(inflight), 32'(live));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NB_REQ; i++) addr_v[i] = ROM_AW'($urandom);
        repeat (3) @(posedge clock_50);
        #1;
        reset_n = 1'b1;

        idle(10);

        addr_v[REQ_P2] = 12'h1A3;
        step(4'b0100, 1'b0);
        idle(6);

        repeat (8) step(4'b1111, 1'b0);
        idle(6);

        repeat (5) step(4'b0001, 1'b0);
        repeat (6) step(4'b1001, 1'b0);
        idle(6);

        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        idle(2);
        step(4'b1000, 1'b0);
        idle(6);

        repeat (5) step(4'b1111, 1'b0);
        do_reset(3);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        idle(6);

        for (int n = 0; n < 300; n++) begin
            step(NB_REQ'($urandom_range(0, (1 << NB_REQ) - 1)), $urandom_range(0, 15) == 0);
        end
        idle(8);

        @(negedge clock_50);
        #1;
        chk("drain", 32'(ret_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
